// File: rtl/fcl_pkg.sv
// Shared constants and types for the FCL1->FCL2 vector hand-off.
// Both ends import this so they agree on the frame grid and boundary position.
package fcl_pkg;
  localparam int WORD_W    = 16;
  localparam int N_WORD    = 16;
  localparam int CNT_MAX   = 25;
  localparam int LINE_MAX  = 30;
  localparam int CNT_INIT  = 16;
  localparam int LINE_INIT = 6;

  localparam int CNT_W  = 5;
  localparam int LINE_W = 5;
  localparam int WPTR_W = 4;

  // Boundary strike position on the (line, count) grid.
  localparam logic [LINE_W-1:0] BND_LINE = LINE_W'(LINE_MAX);
  localparam logic [CNT_W-1:0]  BND_CNT  = CNT_W'(CNT_MAX);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } tx_state_e;
endpackage

// File: rtl/frame_timer.sv
// Free-running line/count grid timer; strike is high while the grid sits on the frame boundary.
// No latency beyond the state register; never stalls.
module frame_timer
  import fcl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [CNT_W-1:0]  count,
  output logic [LINE_W-1:0] line,
  output logic              strike
);
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LINE_W-1:0] line_q, line_d;

  assign strike = (line_q == BND_LINE) && (count_q == BND_CNT);
  assign count  = count_q;
  assign line   = line_q;

  always_comb begin
    count_d = count_q + CNT_W'(1);
    line_d  = line_q;
    if (count_q == BND_CNT) begin
      count_d = '0;
      line_d  = strike ? LINE_W'(1) : line_q + LINE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_W'(CNT_INIT);
      line_q  <= LINE_W'(LINE_INIT);
    end else begin
      count_q <= count_d;
      line_q  <= line_d;
    end
  end
endmodule

// File: rtl/fcl1_vec_tx.sv
// Collects 16 serial FCL1 words and releases them as one parallel vector on the frame boundary.
// Output one edge after the first boundary following the last word; in_rdy drops while a full vector waits.
module fcl1_vec_tx
  import fcl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [WORD_W-1:0]        in_data,
  output logic                     in_rdy,
  output logic [N_WORD*WORD_W-1:0] out_vec,
  output logic                     out_vld,
  output logic                     err_ovf,
  output logic                     err_udr
);
  logic [CNT_W-1:0]  tmr_count;
  logic [LINE_W-1:0] tmr_line;
  logic              bnd;

  frame_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .count  (tmr_count),
    .line   (tmr_line),
    .strike (bnd)
  );

  tx_state_e                        state_q, state_d;
  logic [WPTR_W-1:0]                wptr_q, wptr_d;
  logic [N_WORD-1:0][WORD_W-1:0]    shadow_q, shadow_d;
  logic [N_WORD-1:0][WORD_W-1:0]    out_vec_q, out_vec_d;
  logic                             out_vld_q, out_vld_d;
  logic                             err_ovf_q, err_ovf_d;
  logic                             err_udr_q, err_udr_d;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    shadow_d  = shadow_q;
    out_vec_d = out_vec_q;
    out_vld_d = 1'b0;
    err_ovf_d = err_ovf_q;
    err_udr_d = err_udr_q;
    in_rdy    = (state_q == FILL);
    case (state_q)
      FILL: begin
        if (in_vld) begin
          shadow_d[wptr_q] = in_data;
          if (wptr_q == WPTR_W'(N_WORD - 1)) begin
            wptr_d  = '0;
            state_d = FULL;
          end else begin
            wptr_d = wptr_q + WPTR_W'(1);
          end
        end
        // Boundary with an incomplete vector: keep collecting, flag the miss.
        if (bnd) err_udr_d = 1'b1;
      end
      FULL: begin
        if (in_vld) err_ovf_d = 1'b1;
        if (bnd) begin
          out_vec_d = shadow_q;
          out_vld_d = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      wptr_q    <= '0;
      out_vec_q <= '0;
      out_vld_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      out_vec_q <= out_vec_d;
      out_vld_q <= out_vld_d;
      err_ovf_q <= err_ovf_d;
      err_udr_q <= err_udr_d;
    end
  end

  // Shadow is never read before a full refill, so it needs no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign out_vec = out_vec_q;
  assign out_vld = out_vld_q;
  assign err_ovf = err_ovf_q;
  assign err_udr = err_udr_q;

  grid_in_range: assert property (@(posedge clk) disable iff (rst)
    (tmr_count <= BND_CNT) && (tmr_line >= LINE_W'(1)) && (tmr_line <= BND_LINE));
endmodule

// File: tb/tb_fcl1_vec_tx.sv
// Randomized and directed stimulus against a queue-based model of the vector hand-off.
module tb_fcl1_vec_tx;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_vld = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_rdy;
  logic [255:0] out_vec;
  logic         out_vld;
  logic         err_ovf;
  logic         err_udr;

  fcl1_vec_tx dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_data (in_data),
    .in_rdy  (in_rdy),
    .out_vec (out_vec),
    .out_vld (out_vld),
    .err_ovf (err_ovf),
    .err_udr (err_udr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: collected words, last transmitted vector, flags, edge index since reset.
  logic [15:0]  m_q[$];
  logic [255:0] m_vec;
  logic         m_vld, m_ovf, m_udr;
  int           m_edge;
  int           pulses;

  localparam int FIRST_BND = 634;
  localparam int PERIOD    = 780;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t edge=%0d got=%h exp=%h", tag, $time, m_edge, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_vec  = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_udr  = 1'b0;
    m_edge = 0;
  endtask

  task automatic model_edge(input logic vld, input logic [15:0] data);
    logic bnd;
    m_edge++;
    bnd   = (m_edge >= FIRST_BND) && ((m_edge - FIRST_BND) % PERIOD == 0);
    m_vld = 1'b0;
    if (m_q.size() == 16) begin
      if (vld) m_ovf = 1'b1;
      if (bnd) begin
        for (int k = 0; k < 16; k++) m_vec[k*16 +: 16] = m_q[k];
        m_vld = 1'b1;
        m_q.delete();
      end
    end else begin
      if (vld) m_q.push_back(data);
      if (bnd) m_udr = 1'b1;
    end
  endtask

  // Called at a negedge: check state, drive inputs, take one edge, return at the next negedge.
  task automatic step(input logic vld, input logic [15:0] data);
    chk("in_rdy",  {255'd0, in_rdy},  {255'd0, (m_q.size() < 16)});
    chk("out_vld", {255'd0, out_vld}, {255'd0, m_vld});
    chk("out_vec", out_vec, m_vec);
    chk("err_ovf", {255'd0, err_ovf}, {255'd0, m_ovf});
    chk("err_udr", {255'd0, err_udr}, {255'd0, m_udr});
    if (out_vld === 1'b1) pulses++;
    in_vld  = vld;
    in_data = data;
    @(posedge clk);
    model_edge(vld, data);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    in_vld = 1'b0;
    #1;
    chk("rst_out_vld", {255'd0, out_vld}, 256'd0);
    chk("rst_out_vec", out_vec, 256'd0);
    chk("rst_err_ovf", {255'd0, err_ovf}, 256'd0);
    chk("rst_err_udr", {255'd0, err_udr}, 256'd0);
    chk("rst_in_rdy",  {255'd0, in_rdy},  256'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int p0;
    model_reset();
    pulses = 0;
    @(negedge clk);

    // Idle frame: only an underrun should appear.
    do_reset();
    idle(640);
    chk("idle_no_pulse", 256'(pulses), 256'd0);

    // Two vectors one period apart, then overflow attempts during FULL.
    do_reset();
    p0 = pulses;
    idle(1);
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i));
    idle(FIRST_BND + 5 - m_edge);
    chk("first_word", {240'd0, out_vec[15:0]},    256'h0001);
    chk("last_word",  {240'd0, out_vec[255:240]}, 256'h0010);
    for (int i = 0; i < 16; i++) step(1'b1, 16'hA000 + 16'(i));
    for (int i = 0; i < 50; i++) step(1'b1, 16'hDEAD);
    idle(FIRST_BND + PERIOD + 5 - m_edge);
    chk("a_first_word", {240'd0, out_vec[15:0]},    256'hA000);
    chk("a_last_word",  {240'd0, out_vec[255:240]}, 256'hA00F);
    chk("two_pulses",   256'(pulses - p0), 256'd2);

    // Last word lands exactly on the boundary edge.
    do_reset();
    p0 = pulses;
    idle(FIRST_BND - 16);
    for (int i = 0; i < 16; i++) step(1'b1, 16'h5500 + 16'(i));
    idle(FIRST_BND + PERIOD + 3 - m_edge);
    chk("late_one_pulse", 256'(pulses - p0), 256'd1);

    // Reset mid-fill abandons the partial vector.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 16'h0900 + 16'(i));
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'h0100 + 16'(i));
    idle(FIRST_BND + 3 - m_edge);
    chk("fresh_word0", {240'd0, out_vec[15:0]}, 256'h0100);

    // Random traffic across several frames.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      step(($urandom % 10) < 3, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
